// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int num_req    = 4,
  parameter int max_burst  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            req_ack,
  output logic [num_req-1:0]            gnt,
  input  logic                          full,
  output logic                          wr,
  output logic [data_width-1:0]         wdata,
  output logic                          stall
);

  localparam int ptr_w  = $clog2(num_req);
  localparam int bcnt_w = $clog2(max_burst + 1);

  localparam logic [0:0] s_idle  = 1'b0;
  localparam logic [0:0] s_burst = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [num_req-1:0] gnt_q, gnt_d;
  logic [ptr_w-1:0]   ptr_q, ptr_d;
  logic [bcnt_w-1:0]  bcnt_q, bcnt_d;

  int   g_idx;
  int   cand;
  logic held;
  logic sel_valid;
  logic found;
  logic rel;

  // gnt_q is one-hot or zero, so the last set bit is the granted index.
  always_comb begin
    g_idx = 0;
    for (int i = 0; i < num_req; i++) begin
      if (gnt_q[i]) g_idx = i;
    end
  end

  assign held      = |gnt_q;
  assign sel_valid = |(gnt_q & req_valid);
  assign wr        = sel_valid & ~full & ~rst;
  assign stall     = sel_valid & full & ~rst;
  assign req_ack   = wr ? gnt_q : '0;
  assign wdata     = held ? req_data[g_idx*data_width +: data_width] : '0;
  assign gnt       = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    found   = 1'b0;
    cand    = 0;
    rel     = 1'b0;
    case (state_q)
      s_idle: begin
        // First valid requester at or after ptr, wrapping around.
        for (int i = 0; i < num_req; i++) begin
          cand = (int'(ptr_q) + i) % num_req;
          if (!found && req_valid[cand]) begin
            found       = 1'b1;
            gnt_d       = '0;
            gnt_d[cand] = 1'b1;
          end
        end
        if (found) begin
          bcnt_d  = '0;
          state_d = s_burst;
        end
      end
      s_burst: begin
        rel = ~sel_valid;
        if (wr) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_d == bcnt_w'(max_burst)) rel = 1'b1;
        end
        if (rel) begin
          gnt_d   = '0;
          ptr_d   = (g_idx == num_req - 1) ? '0 : ptr_w'(g_idx + 1);
          state_d = s_idle;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = s_idle;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q <= s_idle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule
